muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 148 ++++++++++++++
 tb/tb_muldiv_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequential radix-2 multiplier / restoring divider
// Signed ops are computed on magnitudes and sign-corrected in a final FIX cycle.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIX} state_t;

    state_t             r_state, w_next;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_b, r_mcand, r_acc_hi, r_acc_lo;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_div_zero, r_done, r_neg_q, r_neg_r;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept, w_last, w_a_neg, w_b_neg, w_div_zero;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quo, w_rem;
    logic [WIDTH:0]     w_sum, w_rem_sh, w_diff;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;

    // FIX also accepts start so back-to-back issue keeps a WIDTH+2 cadence
    assign w_accept = !flush && start && (r_state == S_IDLE || r_state == S_FIX);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_next = S_PREP;
                S_PREP:  w_next = S_CALC;
                S_CALC:  if (w_last) w_next = S_FIX;
                S_FIX:   w_next = start ? S_PREP : S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (r_state != S_IDLE);
    end

    assign w_a_neg = !r_op[0] && r_a[WIDTH-1];
    assign w_b_neg = !r_op[0] && r_b[WIDTH-1];
    assign w_mag_a = w_a_neg ? -r_a : r_a;
    assign w_mag_b = w_b_neg ? -r_b : r_b;

    assign w_sum    = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mcand} : '0);
    assign w_rem_sh = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_mcand};

    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo      = r_neg_q ? -r_acc_lo : r_acc_lo;
    assign w_rem      = r_neg_r ? -r_acc_hi : r_acc_hi;
    assign w_div_zero = r_op[1] && (r_b == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_mcand    <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_op <= op;
                r_a  <= a;
                r_b  <= b;
            end
            case (r_state)
                S_PREP: begin
                    r_acc_hi <= '0;
                    r_acc_lo <= w_mag_a;
                    r_mcand  <= w_mag_b;
                    r_neg_q  <= w_a_neg ^ w_b_neg;
                    r_neg_r  <= w_a_neg;
                    r_cnt    <= '0;
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!r_op[1]) begin
                        r_acc_hi <= w_sum[WIDTH:1];
                        r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
                    end else if (!w_diff[WIDTH]) begin
                        r_acc_hi <= w_diff[WIDTH-1:0];
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_acc_hi <= w_rem_sh[WIDTH-1:0];
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b0};
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        r_done     <= 1'b1;
                        r_div_zero <= w_div_zero;
                        if (!r_op[1]) begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end else if (w_div_zero) begin
                            r_hi <= '0;
                            r_lo <= '0;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign done     = r_done;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - randomized self-checking bench for muldiv_seq
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_dz = 1'b0;

    muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                  output logic [31:0] h, output logic [31:0] l, output logic dz);
        longint p, q, r;
        dz = 1'b0;
        p = 0; q = 0; r = 0;
        case (mop)
            2'b00: p = longint'($signed(ma)) * longint'($signed(mb));
            2'b01: p = longint'({32'b0, ma}) * longint'({32'b0, mb});
            2'b10: if (mb != 0) begin
                       q = longint'($signed(ma)) / longint'($signed(mb));
                       r = longint'($signed(ma)) % longint'($signed(mb));
                   end
            default: if (mb != 0) begin
                       q = longint'({32'b0, ma}) / longint'({32'b0, mb});
                       r = longint'({32'b0, ma}) % longint'({32'b0, mb});
                   end
        endcase
        if (!mop[1]) begin
            h = p[63:32];
            l = p[31:0];
        end else begin
            dz = (mb == 0);
            h = r[31:0];
            l = q[31:0];
        end
    endfunction

    // Issues one operation, scrambles inputs after acceptance, checks latency and result
    task automatic do_op(input logic [1:0] xop, input logic [31:0] xa, input logic [31:0] xb);
        logic [31:0] eh, el;
        logic        edz;
        int k;
        model(xop, xa, xb, eh, el, edz);
        @(negedge clk);
        start = 1'b1; op = xop; a = xa; b = xb;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
            if (k == 10) begin
                check("busy_mid", 64'(busy), 64'd1);
                check("hold_mid", {hi, lo}, {m_hi, m_lo});
            end
        end while (!done && k < 50);
        check("latency", 64'(k), 64'd34);
        check("result", {hi, lo}, {eh, el});
        check("div_zero", 64'(div_zero), 64'(edz));
        check("busy_end", 64'(busy), 64'd0);
        m_hi = eh; m_lo = el; m_dz = edz;
        @(posedge clk); #1;
        check("done_1cyc", 64'(done), 64'd0);
    endtask

    task automatic watch_no_done(input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("no_done", 64'(seen), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        int k;

        #2;
        check("rst_out", {31'b0, busy, done, div_zero, hi, lo}, '0);
        #20;
        @(negedge clk); rst_n = 1'b1;

        do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        do_op(2'b11, 32'h0000_0007, 32'h0000_0000);
        do_op(2'b01, 32'h0000_0002, 32'h0000_0003);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(2'b10, 32'h8000_0001, 32'h0000_0000);
        do_op(2'b00, 32'h0000_0000, 32'h8000_0000);
        do_op(2'b10, 32'h0000_0000, 32'hFFFF_FFF3);
        do_op(2'b00, 32'h8000_0000, 32'h8000_0000);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'($urandom_range(0, 3));
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            do_op(rop, ra, rb);
        end

        // Back-to-back: start held high across the completion edge
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'h8000_0000; b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!done && k < 50);
        check("b2b_first", 64'(k), 64'd34);
        start = 1'b0;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!done && k < 50);
        check("b2b_gap", 64'(k), 64'd34);
        check("b2b_result", {hi, lo}, {32'h0, 32'h8000_0000});
        m_hi = 32'h0; m_lo = 32'h8000_0000; m_dz = 1'b0;

        // Flush mid-operation
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        watch_no_done(40);
        check("flush_hold", {31'b0, div_zero, hi, lo}, {31'b0, m_dz, m_hi, m_lo});

        // Asynchronous reset mid-operation
        do_op(2'b11, 32'h0000_0009, 32'h0000_0000);
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'h0000_0007; b = 32'h0000_0003;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_async", {31'b0, busy, done, div_zero, hi, lo}, '0);
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        watch_no_done(40);
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
